// File: rtl/reg_cmd_pkg.sv
// ============================================================================
// Module  : reg_cmd_pkg
// Brief   : Shared constants and state encoding for the command sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_cmd_pkg;

    localparam logic [7:0]  c_MAGIC    = 8'hAA;
    localparam logic [7:0]  c_RW_READ  = 8'h00;
    localparam logic [7:0]  c_RW_WRITE = 8'h01;
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;

    // Frame byte states are consecutive so "next byte" is a plain increment.
    typedef enum logic [3:0] {
        HUNT  = 4'd0,
        RW    = 4'd1,
        ADDR0 = 4'd2,
        ADDR1 = 4'd3,
        VAL0  = 4'd4,
        VAL1  = 4'd5,
        VAL2  = 4'd6,
        VAL3  = 4'd7,
        ISSUE = 4'd8,
        WAIT  = 4'd9,
        REPLY = 4'd10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_reply_ser.sv
// ============================================================================
// Module  : reg_reply_ser
// Brief   : Loads a 32-bit word and emits it as 4 bytes, LSB first, valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_reply_ser (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_data,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_done
);

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_valid;
    logic        w_fire;

    assign w_fire  = r_valid & i_ready;
    assign o_data  = r_shift[7:0];
    assign o_valid = r_valid;
    assign o_done  = w_fire & (r_cnt == 2'd3);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= 32'h0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= 2'd0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_shift <= {8'h00, r_shift[31:8]};
            r_cnt   <= r_cnt + 2'd1;
            if (r_cnt == 2'd3)
                r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_cmd_sequencer.sv
// ============================================================================
// Module  : reg_cmd_sequencer
// Brief   : Frames 8-byte FX2 commands into register accesses, returns 4-byte reply.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_cmd_sequencer
    import reg_cmd_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned BYTE_TIMEOUT = 4096,
    parameter logic [7:0]  MAGIC        = c_MAGIC
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_cmd_data,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    output logic [15:0] o_reg_addr,
    output logic [31:0] o_reg_wdata,
    output logic        o_reg_wr,
    output logic        o_reg_rd,
    input  logic [31:0] i_reg_rdata,
    input  logic        i_reg_ack,
    output logic [7:0]  o_reply_data,
    output logic        o_reply_valid,
    input  logic        i_reply_ready,
    output logic        o_busy,
    output logic [15:0] o_sync_errs,
    output logic        o_timeout_flag
);

    localparam int c_BW = $clog2(BYTE_TIMEOUT + 1);
    localparam int c_AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_BW-1:0] c_BYTE_MAX = c_BW'(BYTE_TIMEOUT - 1);
    localparam logic [c_AW-1:0] c_ACK_MAX  = c_AW'(ACK_TIMEOUT - 1);

    state_t          r_state, w_state_nxt;
    logic            r_rdy_en;
    logic            r_is_write;
    logic [15:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [15:0]     r_sync_errs;
    logic            r_timeout;
    logic [c_BW-1:0] r_byte_idle;
    logic [c_AW-1:0] r_ack_cnt;

    logic            w_in_frame, w_hunting, w_accept, w_byte_to, w_ack_to;
    logic            w_sync_inc, w_load, w_done;
    logic [31:0]     w_load_data;

    assign w_in_frame = (r_state >= RW) && (r_state <= VAL3);
    assign w_hunting  = (r_state == HUNT);
    assign w_accept   = i_cmd_valid & o_cmd_ready;
    assign w_byte_to  = w_in_frame & ~i_cmd_valid & (r_byte_idle == c_BYTE_MAX);
    assign w_ack_to   = (r_state == WAIT) & ~i_reg_ack & (r_ack_cnt == c_ACK_MAX);

    assign o_cmd_ready    = r_rdy_en & (w_hunting | w_in_frame);
    assign o_reg_wr       = (r_state == ISSUE) &  r_is_write;
    assign o_reg_rd       = (r_state == ISSUE) & ~r_is_write;
    assign o_reg_addr     = r_addr;
    assign o_reg_wdata    = r_wdata;
    assign o_busy         = ~w_hunting;
    assign o_sync_errs    = r_sync_errs;
    assign o_timeout_flag = r_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_sync_inc  = 1'b0;
        w_load      = 1'b0;
        w_load_data = i_reg_rdata;
        case (r_state)
            HUNT: begin
                if (w_accept) begin
                    if (i_cmd_data == MAGIC) w_state_nxt = RW;
                    else                     w_sync_inc  = 1'b1;
                end
            end
            RW: begin
                if (w_accept) begin
                    if (i_cmd_data == c_RW_READ || i_cmd_data == c_RW_WRITE) begin
                        w_state_nxt = ADDR0;
                    end else begin
                        w_state_nxt = HUNT;
                        w_sync_inc  = 1'b1;
                    end
                end else if (w_byte_to) begin
                    w_state_nxt = HUNT;
                    w_sync_inc  = 1'b1;
                end
            end
            ADDR0, ADDR1, VAL0, VAL1, VAL2, VAL3: begin
                if (w_accept) begin
                    w_state_nxt = state_t'(r_state + 4'd1);
                end else if (w_byte_to) begin
                    w_state_nxt = HUNT;
                    w_sync_inc  = 1'b1;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (i_reg_ack) begin
                    w_load      = 1'b1;
                    w_state_nxt = REPLY;
                end else if (w_ack_to) begin
                    w_load      = 1'b1;
                    w_load_data = c_ALL_ONES;
                    w_state_nxt = REPLY;
                end
            end
            REPLY: begin
                if (w_done) w_state_nxt = HUNT;
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= HUNT;
            r_rdy_en    <= 1'b0;
            r_is_write  <= 1'b0;
            r_addr      <= 16'h0;
            r_wdata     <= 32'h0;
            r_sync_errs <= 16'h0;
            r_timeout   <= 1'b0;
            r_byte_idle <= '0;
            r_ack_cnt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                case (r_state)
                    RW:    r_is_write <= i_cmd_data[0];
                    ADDR0: r_addr[7:0]  <= i_cmd_data;
                    ADDR1: r_addr[15:8] <= i_cmd_data;
                    VAL0:  if (r_is_write) r_wdata[7:0]   <= i_cmd_data;
                    VAL1:  if (r_is_write) r_wdata[15:8]  <= i_cmd_data;
                    VAL2:  if (r_is_write) r_wdata[23:16] <= i_cmd_data;
                    VAL3:  if (r_is_write) r_wdata[31:24] <= i_cmd_data;
                    default: ;
                endcase
            end
            if (w_sync_inc && r_sync_errs != 16'hFFFF)
                r_sync_errs <= r_sync_errs + 16'd1;
            if (w_ack_to)
                r_timeout <= 1'b1;
            // Idle counter restarts on every presented byte, not only on accepts.
            if (!w_in_frame || i_cmd_valid) r_byte_idle <= '0;
            else                            r_byte_idle <= r_byte_idle + 1'b1;
            if (r_state != WAIT) r_ack_cnt <= '0;
            else                 r_ack_cnt <= r_ack_cnt + 1'b1;
        end
    end

    reg_reply_ser u_ser (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .o_data  (o_reply_data),
        .o_valid (o_reply_valid),
        .i_ready (i_reply_ready),
        .o_done  (w_done)
    );

endmodule

`default_nettype wire

// File: doc/reg_cmd_sequencer.md
Name: reg_cmd_sequencer

Overview:
- Controller between the FX2 OUT-FIFO command byte stream and the internal register bus of the timetagger (capture control, strobe/delta enables, sequencer channel registers).
- Frames 8-byte commands: 0xAA magic, rw byte, addr LSB-first, value LSB-first.
- Issues one register read or write and waits for the ack.
- Streams the 4-byte reply, LSB first, toward the FX2 IN path.

Parameters:
- ACK_TIMEOUT, 64, clk cycles to wait for reg_ack before the transaction is abandoned.
- BYTE_TIMEOUT, 4096, max idle clk cycles between bytes of one frame before the frame is aborted.
- MAGIC, 8'hAA, frame start byte.

Ports:
- clk  in  1  single clock (FX2 interface clock domain).
- reset  in  1  asynchronous, active-high reset.
- cmd_data  in  8  command byte from OUT FIFO.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  byte accepted when cmd_valid & cmd_ready.
- reg_addr  out  16  register address.
- reg_wdata  out  32  write value.
- reg_wr  out  1  one-cycle write strobe.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  32  register value, sampled on reg_ack.
- reg_ack  in  1  one-cycle completion from register file.
- reply_data  out  8  reply byte.
- reply_valid  out  1  reply_data valid.
- reply_ready  in  1  byte consumed when reply_valid & reply_ready.
- busy  out  1  high from magic accepted until last reply byte consumed.
- sync_errs  out  16  saturating count of discarded/aborted bytes and frames.
- timeout_flag  out  1  sticky; set on ack timeout, cleared by reset only.

Behaviour:
- Reset (async, any state): state HUNT; reg_wr=reg_rd=0; reply_valid=0; busy=0; reg_addr=0; reg_wdata=0; sync_errs=0; timeout_flag=0; cmd_ready=0 for the first cycle after release, then 1.
- Reset mid-frame or mid-reply drops all partial data; no strobe is issued after reset release.
- cmd_ready=1 only in HUNT, RW and ADDR0..VAL3; it is 0 in ISSUE, WAIT, REPLY.
- HUNT: byte==MAGIC -> RW. Any other byte is discarded and sync_errs++.
- RW: byte 0x00=read, 0x01=write -> ADDR0. Any other value -> HUNT, sync_errs++.
- ADDR0, ADDR1, VAL0..VAL3: capture bytes LSB first. A read frame still consumes 4 value bytes, which are ignored.
- ISSUE: exactly one cycle; reg_wr (write) or reg_rd (read) high; addr/wdata stable from ISSUE until ack or timeout -> WAIT.
- WAIT: reg_ack -> latch reg_rdata into the reply shift reg -> REPLY.
- WAIT timeout: ACK_TIMEOUT cycles without ack -> reply 32'hFFFFFFFF, set timeout_flag -> REPLY.
- reg_ack outside WAIT is ignored.
- A write reply returns reg_rdata presented with the ack (read-back value).
- REPLY: 4 bytes, [7:0] first; each held until reply_ready; after the 4th handshake -> HUNT, busy=0.
- Minimum latency: the last value byte is accepted on cycle N; reg_wr/reg_rd is high on N+1; with ack on N+2, reply_valid is high on N+3.
- Byte timeout: in RW..VAL3, BYTE_TIMEOUT cycles without cmd_valid -> HUNT, sync_errs++, no register access.
- sync_errs saturates at 16'hFFFF.
- 0xAA appearing as an addr/value byte is data, not resync.

Decomposition:
- Package reg_cmd_pkg holds:
  - MAGIC constant.
  - RW_READ/RW_WRITE constants.
  - State enum: HUNT, RW, ADDR0, ADDR1, VAL0, VAL1, VAL2, VAL3, ISSUE, WAIT, REPLY.
  - ALL_ONES reply constant.
- One sub-module, reg_reply_ser: a 32-bit load, 4-byte LSB-first valid/ready serializer with a done pulse.

Test Plan:
- Garbage FF FF FF then a read of 0x0001 with rdata 0x00000003 -> sync_errs=3; one reg_rd with addr 0x0001; reply bytes 03 00 00 00.
- Write 0x0004 value 0x0000000F, ack after 2 cycles with rdata 0x0F -> single reg_wr, wdata 0x0000000F; reply 0F 00 00 00; busy low after the 4th byte.
- Write 0x0003 value 0x03 with reg_ack never asserted -> reply FF FF FF FF after ACK_TIMEOUT; timeout_flag=1; next command works normally.
- Frame AA 01 28 then stall BYTE_TIMEOUT cycles -> back to HUNT; sync_errs+1; no reg_wr; next full frame is accepted.
- reply_ready held low 20 cycles mid-reply -> reply_data is stable and no bytes are lost; cmd_ready stays 0 until the reply completes.
- Assert reset during WAIT, then release and send a read of 0x0002 -> no stale strobe; fresh reply only.
